// File: rtl/seven_segment_fun_pkg.sv
// Shared mode encodings and segment patterns for the seven-segment demo tile.
// Segment bit order is {g,f,e,d,c,b,a}, active-high (common cathode).
package seven_segment_fun_pkg;

   typedef enum logic [1:0] {
      MODE_HEX    = 2'b00,
      MODE_SNAKE  = 2'b01,
      MODE_STATIC = 2'b10,
      MODE_FUN    = 2'b11
   } mode_e;

   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_U     = 7'h3E;
   localparam logic [6:0] SEG_N     = 7'h54;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Highest animation position for each mode; static mode never moves.
   function automatic logic [3:0] pos_limit(input mode_e mode);
      case (mode)
         MODE_HEX:   pos_limit = 4'd15;
         MODE_SNAKE: pos_limit = 4'd5;
         MODE_FUN:   pos_limit = 4'd3;
         default:    pos_limit = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/seven_segment_fun_seg7_hex_decoder.sv
// Combinational 4-bit value to seven-segment hex glyph.
module seg7_hex_decoder
   import seven_segment_fun_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[value];

endmodule

// File: rtl/seven_segment_fun.sv
// Tiny Tapeout tile: hex counter, snake, static hex and scrolling "FUN" on one
// seven-segment digit, stepping on a prescaled tick, with a heartbeat decimal point.
module seven_segment_fun
   import seven_segment_fun_pkg::*;
#(
   parameter int TICK_DIV = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] presc;
   logic [3:0]    pos;
   logic [3:0]    pos_next;
   logic [3:0]    pos_max;
   logic          dp;
   mode_e         mode_q;
   mode_e         mode_in;
   logic          mode_change;
   logic          pause;
   logic          rev;
   logic          tick;
   logic [6:0]    seg;
   logic [6:0]    hex_pos_seg;
   logic [6:0]    hex_in_seg;
   logic          unused_pins;

   assign mode_in     = mode_e'(ui_in[1:0]);
   assign pause       = ui_in[2];
   assign rev         = ui_in[3];
   assign mode_change = (mode_in != mode_q);
   // A mode change swallows any tick landing in the same cycle.
   assign tick        = !mode_change && !pause && (presc == PRESC_LAST);
   assign unused_pins = ^{uio_in, ena};

   always_comb begin
      pos_max  = pos_limit(mode_q);
      pos_next = pos;
      if (mode_change) begin
         pos_next = 4'd0;
      end else if (tick && (mode_q != MODE_STATIC)) begin
         if (rev) pos_next = (pos == 4'd0)    ? pos_max : pos - 4'd1;
         else     pos_next = (pos == pos_max) ? 4'd0    : pos + 4'd1;
      end
   end

   seg7_hex_decoder u_hex_pos (.value(pos),         .seg(hex_pos_seg));
   seg7_hex_decoder u_hex_in  (.value(ui_in[7:4]),  .seg(hex_in_seg));

   // Decode against the registered mode so pos is always in range for its mode.
   always_comb begin
      seg = SEG_BLANK;
      case (mode_q)
         MODE_HEX:    seg = hex_pos_seg;
         MODE_SNAKE:  seg = (pos < 4'd6) ? (7'b000_0001 << pos) : SEG_BLANK;
         MODE_STATIC: seg = hex_in_seg;
         MODE_FUN: begin
            case (pos)
               4'd0:    seg = SEG_F;
               4'd1:    seg = SEG_U;
               4'd2:    seg = SEG_N;
               default: seg = SEG_BLANK;
            endcase
         end
         default:     seg = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc  <= '0;
         pos    <= 4'd0;
         dp     <= 1'b0;
         uo_out <= 8'h00;
         mode_q <= MODE_HEX;
      end else begin
         mode_q <= mode_in;
         pos    <= pos_next;
         uo_out <= {dp, seg};
         if (mode_change)  presc <= '0;
         else if (tick)    presc <= '0;
         else if (!pause)  presc <= presc + 1'b1;
         if (tick) dp <= ~dp;
      end
   end

   assign uio_out = {4'b0000, pos};
   assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_seven_segment_fun.sv
// Bench for seven_segment_fun: per-cycle scoreboard against a behavioural model,
// a literal vector table, and a full hex-counter sweep.
module tb_seven_segment_fun;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       ena;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];

   logic [6:0] hex_tab [16];
   logic [6:0] snake_tab [6];
   logic [6:0] fun_tab [4];

   int         m_presc;
   int         m_pos;
   logic       m_dp;
   logic [1:0] m_mode;

   typedef struct {
      bit         do_rst;
      logic [7:0] ui;
      int         cycles;
      logic [6:0] seg;
      logic [3:0] pos;
   } vec_t;

   vec_t vecs[$];

   seven_segment_fun #(.TICK_DIV(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] model_seg(input logic [1:0] md, input int p, input logic [3:0] v);
      case (md)
         2'b00:   return hex_tab[p];
         2'b01:   return (p < 6) ? snake_tab[p] : 7'h00;
         2'b10:   return hex_tab[v];
         default: return (p < 4) ? fun_tab[p] : 7'h00;
      endcase
   endfunction

   // Drive one clock cycle, predict the registered outputs, compare after the edge.
   task automatic cycle(input logic [7:0] ui, input logic r);
      logic [7:0]  nuo;
      logic [15:0] exp;
      int          n;
      ui_in = ui;
      rst   = r;
      if (r) begin
         m_presc = 0; m_pos = 0; m_dp = 1'b0; m_mode = 2'b00; nuo = 8'h00;
      end else begin
         nuo = {m_dp, model_seg(m_mode, m_pos, ui[7:4])};
         if (ui[1:0] != m_mode) begin
            m_pos = 0; m_presc = 0;
         end else if (!ui[2]) begin
            if (m_presc == 3) begin
               m_presc = 0;
               m_dp    = ~m_dp;
               n = (m_mode == 2'b00) ? 16 : (m_mode == 2'b01) ? 6 : (m_mode == 2'b11) ? 4 : 0;
               if (n != 0) m_pos = ui[3] ? (m_pos + n - 1) % n : (m_pos + 1) % n;
            end else begin
               m_presc = m_presc + 1;
            end
         end
         m_mode = ui[1:0];
      end
      exp_q.push_back({nuo, 4'h0, 4'(m_pos)});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({uo_out, uio_out} !== exp || uio_oe !== 8'h0F) begin
         errors++;
         $display("FAIL scoreboard t=%0t ui_in=%h: uo_out=%h uio_out=%h uio_oe=%h expected %h %h 0f",
                  $time, ui, uo_out, uio_out, uio_oe, exp[15:8], exp[7:0]);
      end
   endtask

   task automatic do_reset(input logic [7:0] ui);
      cycle(ui, 1'b1);
      cycle(ui, 1'b1);
      checks++;
      if (uo_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_uo_out: got %h expected 00", uo_out);
      end
   endtask

   initial begin
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      snake_tab = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};
      fun_tab   = '{7'h71, 7'h3E, 7'h54, 7'h00};
      uio_in = 8'($urandom_range(0, 255));
      ena    = 1'b1;
      rst    = 1'b1;
      ui_in  = 8'h00;

      // Reset, then 17 ticks of the hex counter counting up.
      do_reset(8'h00);
      cycle(8'h00, 1'b0);
      for (int m = 0; m < 18; m++) begin
         checks++;
         if (uo_out[6:0] !== hex_tab[m % 16] || uo_out[7] !== m[0] || uio_out !== 8'(m % 16)) begin
            errors++;
            $display("FAIL hex_sweep step %0d: uo_out=%h uio_out=%h expected %h %h",
                     m, uo_out, uio_out, {m[0], hex_tab[m % 16]}, 8'(m % 16));
         end
         for (int c = 0; c < 4; c++) cycle(8'h00, 1'b0);
      end

      // Reverse hex
      vecs.push_back('{1, 8'h08, 1, 7'h3F, 4'h0});
      vecs.push_back('{0, 8'h08, 4, 7'h71, 4'hF});
      vecs.push_back('{0, 8'h08, 4, 7'h79, 4'hE});
      // Snake forward then reverse
      vecs.push_back('{1, 8'h01, 2, 7'h01, 4'h0});
      vecs.push_back('{0, 8'h01, 4, 7'h02, 4'h1});
      vecs.push_back('{0, 8'h01, 4, 7'h04, 4'h2});
      vecs.push_back('{0, 8'h01, 4, 7'h08, 4'h3});
      vecs.push_back('{0, 8'h01, 4, 7'h10, 4'h4});
      vecs.push_back('{0, 8'h01, 4, 7'h20, 4'h5});
      vecs.push_back('{0, 8'h01, 4, 7'h01, 4'h0});
      vecs.push_back('{0, 8'h09, 4, 7'h20, 4'h5});
      vecs.push_back('{0, 8'h09, 4, 7'h10, 4'h4});
      vecs.push_back('{0, 8'h09, 4, 7'h08, 4'h3});
      // Static digit follows ui_in[7:4] without waiting for a tick
      vecs.push_back('{1, 8'hA2, 2, 7'h77, 4'h0});
      vecs.push_back('{0, 8'h52, 1, 7'h6D, 4'h0});
      vecs.push_back('{0, 8'h52, 8, 7'h6D, 4'h0});
      // FUN, pause, mode change while paused
      vecs.push_back('{1, 8'h03, 2, 7'h71, 4'h0});
      vecs.push_back('{0, 8'h03, 4, 7'h3E, 4'h1});
      vecs.push_back('{0, 8'h03, 4, 7'h54, 4'h2});
      vecs.push_back('{0, 8'h03, 4, 7'h00, 4'h3});
      vecs.push_back('{0, 8'h03, 4, 7'h71, 4'h0});
      vecs.push_back('{0, 8'h07, 20, 7'h71, 4'h0});
      vecs.push_back('{0, 8'h04, 1, 7'h71, 4'h0});
      vecs.push_back('{0, 8'h04, 1, 7'h3F, 4'h0});
      vecs.push_back('{0, 8'h04, 6, 7'h3F, 4'h0});
      // Mode change in the same cycle as a tick: change wins, dp holds
      vecs.push_back('{1, 8'h00, 3, 7'h3F, 4'h0});
      vecs.push_back('{0, 8'h01, 1, 7'h3F, 4'h0});
      vecs.push_back('{0, 8'h01, 1, 7'h01, 4'h0});
      vecs.push_back('{0, 8'h01, 4, 7'h02, 4'h1});

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset(vecs[i].ui);
         for (int c = 0; c < vecs[i].cycles; c++) cycle(vecs[i].ui, 1'b0);
         checks++;
         if (uo_out[6:0] !== vecs[i].seg || uio_out !== {4'h0, vecs[i].pos}) begin
            errors++;
            $display("FAIL vector %0d: seg=%h uio_out=%h expected seg=%h uio_out=%h",
                     i, uo_out[6:0], uio_out, vecs[i].seg, {4'h0, vecs[i].pos});
         end
      end

      // Short random soak, scoreboard only
      for (int i = 0; i < 200; i++) begin
         cycle(8'($urandom_range(0, 255)) & ((i % 37 == 0) ? 8'hFF : 8'hF3) | 8'(i[7:6]), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
